// File: rtl/tmds_rx_pkg.sv
// rtl/tmds_rx_pkg.sv - TMDS receive token constants, alignment FSM states and token-to-ctrl mapping
package tmds_rx_pkg;

    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } rx_state_t;

    // Non-token words map to 00; callers qualify with the token flag.
    function automatic logic [1:0] token_ctrl(input logic [9:0] word);
        case (word)
            TOK_01:  return 2'b01;
            TOK_10:  return 2'b10;
            TOK_11:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational TMDS 10b word classify and 8b pixel decode
module tmds_symbol_decode
    import tmds_rx_pkg::*;
(
    input  logic [9:0] raw_i,
    output logic       is_token_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
);

    logic [7:0] w_q;
    logic [7:0] w_x;

    always_comb begin
        w_q        = raw_i[9] ? ~raw_i[7:0] : raw_i[7:0];
        // Bit 0 has no predecessor, so it passes through the XOR unchanged.
        w_x        = w_q ^ {w_q[6:0], 1'b0};
        data_o     = raw_i[8] ? w_x : {~w_x[7:1], w_x[0]};
        is_token_o = (raw_i == TOK_00) || (raw_i == TOK_01) ||
                     (raw_i == TOK_10) || (raw_i == TOK_11);
        ctrl_o     = token_ctrl(raw_i);
    end

endmodule

// File: rtl/tmds_channel_rx.sv
// rtl/tmds_channel_rx.sv - TMDS channel receiver: bitslip alignment search, lock tracking, 2-stage decode
// Optional TMDS_RX_STATS_EN adds saturating slip_count_o / unlock_count_o.
module tmds_channel_rx
    import tmds_rx_pkg::*;
#(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        raw_valid_i,
    input  logic [9:0]  raw_i,
    output logic        bitslip_o,
    output logic        locked_o,
    output logic        valid_o,
    output logic        de_o,
    output logic [7:0]  data_o,
    output logic [1:0]  ctrl_o
`ifdef TMDS_RX_STATS_EN
    ,
    output logic [15:0] slip_count_o,
    output logic [7:0]  unlock_count_o
`endif
);

    localparam int RW = $clog2(TOKEN_RUN + 1);
    localparam int IW = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_FULL  = RW'(TOKEN_RUN);
    localparam logic [RW-1:0] RUN_LAST  = RW'(TOKEN_RUN - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(SEARCH_TIMEOUT - 1);
    localparam logic [IW-1:0] WAIT_LAST = IW'(SLIP_WAIT - 1);

    rx_state_t      r_state;
    rx_state_t      w_state_nxt;
    logic [RW-1:0]  r_run_cnt;
    logic [RW-1:0]  w_run_nxt;
    logic [IW-1:0]  r_idle_cnt;
    logic [IW-1:0]  w_idle_nxt;
    logic           w_slip;
    logic           w_unlock;
    logic           w_locked_nxt;
    logic           r_bitslip;
    logic           r_locked;

    logic           w_is_tok;
    logic [1:0]     w_tok_ctrl;
    logic [7:0]     w_dec_data;

    logic           r_s1_valid;
    logic           r_s1_tok;
    logic [1:0]     r_s1_ctrl;
    logic [7:0]     r_s1_data;
    logic           r_valid;
    logic           r_de;
    logic [7:0]     r_data;
    logic [1:0]     r_ctrl;

    tmds_symbol_decode u_decode (
        .raw_i      (raw_i),
        .is_token_o (w_is_tok),
        .ctrl_o     (w_tok_ctrl),
        .data_o     (w_dec_data)
    );

    // idle_cnt doubles as the settle counter while in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_slip      = 1'b0;
        w_unlock    = 1'b0;
        case (r_state)
            SEARCH, LOCKED: begin
                if (raw_valid_i) begin
                    if (!w_is_tok)
                        w_run_nxt = '0;
                    else if (r_run_cnt != RUN_FULL)
                        w_run_nxt = r_run_cnt + 1'b1;
                    if (w_is_tok && (r_run_cnt == RUN_LAST)) begin
                        w_idle_nxt  = '0;
                        w_state_nxt = LOCKED;
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        w_idle_nxt = '0;
                        if (r_state == SEARCH) begin
                            w_state_nxt = SLIP;
                            w_run_nxt   = '0;
                            w_slip      = 1'b1;
                        end else begin
                            w_state_nxt = SEARCH;
                            w_unlock    = 1'b1;
                        end
                    end else begin
                        w_idle_nxt = r_idle_cnt + 1'b1;
                    end
                end
            end
            SLIP: w_state_nxt = WAIT;
            WAIT: begin
                if (raw_valid_i) begin
                    if (r_idle_cnt == WAIT_LAST) begin
                        w_idle_nxt  = '0;
                        w_state_nxt = SEARCH;
                    end else begin
                        w_idle_nxt = r_idle_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
        w_locked_nxt = (w_state_nxt == LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= SEARCH;
            r_run_cnt  <= '0;
            r_idle_cnt <= '0;
            r_bitslip  <= 1'b0;
            r_locked   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_tok   <= 1'b0;
            r_s1_ctrl  <= '0;
            r_s1_data  <= '0;
            r_valid    <= 1'b0;
            r_de       <= 1'b0;
            r_data     <= '0;
            r_ctrl     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_cnt  <= w_run_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_bitslip  <= w_slip;
            r_locked   <= w_locked_nxt;
            r_s1_valid <= raw_valid_i;
            if (raw_valid_i) begin
                r_s1_tok  <= w_is_tok;
                r_s1_ctrl <= w_tok_ctrl;
                r_s1_data <= w_dec_data;
            end
            // Gate on the post-edge lock state so valid_o never outlives locked_o.
            r_valid <= r_s1_valid && w_locked_nxt;
            if (r_s1_valid && w_locked_nxt) begin
                r_de <= !r_s1_tok;
                if (r_s1_tok)
                    r_ctrl <= r_s1_ctrl;
                else
                    r_data <= r_s1_data;
            end
        end
    end

    assign bitslip_o = r_bitslip;
    assign locked_o  = r_locked;
    assign valid_o   = r_valid;
    assign de_o      = r_de;
    assign data_o    = r_data;
    assign ctrl_o    = r_ctrl;

`ifdef TMDS_RX_STATS_EN
    logic [15:0] r_slip_count;
    logic [7:0]  r_unlock_count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_slip_count   <= '0;
            r_unlock_count <= '0;
        end else begin
            if (w_slip && (r_slip_count != 16'hFFFF))
                r_slip_count <= r_slip_count + 1'b1;
            if (w_unlock && (r_unlock_count != 8'hFF))
                r_unlock_count <= r_unlock_count + 1'b1;
        end
    end

    assign slip_count_o   = r_slip_count;
    assign unlock_count_o = r_unlock_count;
`endif

endmodule

// File: tb/tb_tmds_channel_rx.sv
// tb/tb_tmds_channel_rx.sv - scoreboard bench for tmds_channel_rx against a word-level reference model
module tb_tmds_channel_rx;

    localparam int TOKEN_RUN      = 8;
    localparam int SEARCH_TIMEOUT = 4096;
    localparam int SLIP_WAIT      = 16;
    localparam int M_SEARCH = 0, M_SLIP = 1, M_WAIT = 2, M_LOCKED = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       raw_valid = 1'b0;
    logic [9:0] raw = '0;
    logic       bitslip, locked, valid, de;
    logic [7:0] data;
    logic [1:0] ctrl;
`ifdef TMDS_RX_STATS_EN
    logic [15:0] slip_count;
    logic [7:0]  unlock_count;
`endif

    always #5 clk = ~clk;

    tmds_channel_rx #(
        .TOKEN_RUN      (TOKEN_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .raw_valid_i (raw_valid),
        .raw_i       (raw),
        .bitslip_o   (bitslip),
        .locked_o    (locked),
        .valid_o     (valid),
        .de_o        (de),
        .data_o      (data),
        .ctrl_o      (ctrl)
`ifdef TMDS_RX_STATS_EN
        ,
        .slip_count_o   (slip_count),
        .unlock_count_o (unlock_count)
`endif
    );

    typedef struct {
        int         due;
        bit         tok;
        logic [1:0] ctrl;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] tok_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    bit         lk [65536];
    bit         sl [65536];
    int         e_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         m_st = M_SEARCH, m_run = 0, m_idle = 0, m_wait = 0;
    int         m_slips = 0, m_unlocks = 0;
    bit         m_slip = 1'b0;
    int         ser_off = 0;
    int         dut_slips = 0;
    bit         h_de = 1'b0;
    logic [7:0] h_data = '0;
    logic [1:0] h_ctrl = '0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e_cnt);
        end
    endtask

    function automatic int tok_index(input logic [9:0] w);
        for (int i = 0; i < 4; i++)
            if (w == tok_tab[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] q, d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = w[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
        return d;
    endfunction

    function automatic logic [9:0] rot_word(input logic [9:0] t, input int off);
        logic [9:0] r;
        for (int j = 0; j < 10; j++) r[j] = t[(j + off) % 10];
        return r;
    endfunction

    function automatic void model_reset();
        m_st = M_SEARCH; m_run = 0; m_idle = 0; m_wait = 0;
        m_slips = 0; m_unlocks = 0; m_slip = 1'b0;
        exp_q.delete();
    endfunction

    // State after one clock edge on which word w was (or was not) presented.
    function automatic void model_step(input bit v, input logic [9:0] w);
        int   ti;
        bit   hit;
        exp_t ent;
        ti     = tok_index(w);
        hit    = 1'b0;
        m_slip = 1'b0;
        if (m_st == M_SLIP) begin
            m_st = M_WAIT; m_wait = 0;
        end else if (v && m_st == M_WAIT) begin
            m_wait++;
            if (m_wait == SLIP_WAIT) begin m_st = M_SEARCH; m_run = 0; m_idle = 0; end
        end else if (v) begin
            if (ti < 0) m_run = 0;
            else if (m_run < TOKEN_RUN) begin m_run++; hit = (m_run == TOKEN_RUN); end
            if (hit) begin
                m_idle = 0; m_st = M_LOCKED;
            end else begin
                m_idle++;
                if (m_idle == SEARCH_TIMEOUT) begin
                    m_idle = 0;
                    if (m_st == M_SEARCH) begin m_st = M_SLIP; m_slip = 1'b1; m_run = 0; m_slips++; end
                    else begin m_st = M_SEARCH; m_unlocks++; end
                end
            end
        end
        if (v) begin
            ent.due  = e_cnt + 1;
            ent.tok  = (ti >= 0);
            ent.ctrl = (ti >= 0) ? 2'(ti) : 2'b00;
            ent.data = ref_decode(w);
            exp_q.push_back(ent);
        end
    endfunction

    task automatic drive(input bit v, input logic [9:0] w);
        raw_valid = v;
        raw       = w;
        @(posedge clk);
        e_cnt++;
        if (e_cnt >= 65535) begin
            $display("FAIL cycle_budget: got %0d expected below 65535", e_cnt);
            $fatal(1, "cycle budget exhausted");
        end
        if (!rst_n) model_reset();
        else model_step(v, w);
        lk[e_cnt] = (m_st == M_LOCKED);
        sl[e_cnt] = m_slip;
        #1;
        if (bitslip) begin ser_off = (ser_off + 1) % 10; dut_slips++; end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bitslip", 16'(bitslip), 16'h0);
        chk("rst_locked",  16'(locked),  16'h0);
        chk("rst_valid",   16'(valid),   16'h0);
        chk("rst_de",      16'(de),      16'h0);
        chk("rst_data",    16'(data),    16'h0);
        chk("rst_ctrl",    16'(ctrl),    16'h0);
        model_reset();
        lk[e_cnt] = 1'b0;
        sl[e_cnt] = 1'b0;
        drive(1'b0, '0);
        drive(1'b0, '0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        bit   ev;
        exp_t ent;
        ev = 1'b0;
        if (!rst_n) begin
            h_de = 1'b0; h_data = '0; h_ctrl = '0;
        end else if (exp_q.size() > 0 && exp_q[0].due == e_cnt) begin
            ent = exp_q.pop_front();
            if (lk[e_cnt]) begin
                ev = 1'b1;
                h_de = !ent.tok;
                if (ent.tok) h_ctrl = ent.ctrl;
                else h_data = ent.data;
            end
        end
        chk("valid_o",   16'(valid),   16'(ev));
        chk("locked_o",  16'(locked),  16'(lk[e_cnt]));
        chk("bitslip_o", 16'(bitslip), 16'(sl[e_cnt]));
        chk("de_o",      16'(de),      16'(h_de));
        chk("data_o",    16'(data),    16'(h_data));
        chk("ctrl_o",    16'(ctrl),    16'(h_ctrl));
    end

    initial begin
        int n;
        drive(1'b0, '0);
        drive(1'b0, '0);
        chk("reset_locked", 16'(locked), 16'h0);
        chk("reset_valid",  16'(valid),  16'h0);
        rst_n = 1'b1;

        // Timeout in SEARCH -> single bitslip, then reset while settling.
        dut_slips = 0;
        for (int i = 0; i < SEARCH_TIMEOUT; i++) drive(1'b1, 10'h1F0);
        drive(1'b1, 10'h1F0);
        chk("first_slip_count", 16'(dut_slips), 16'd1);
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) drive(1'b1, 10'h1F0);
        do_reset();

        // Directed lock and decode.
        for (int i = 0; i < TOKEN_RUN; i++) drive(1'b1, 10'h354);
        chk("lock_after_run", 16'(locked), 16'h1);
        drive(1'b1, 10'h354);
        drive(1'b1, 10'h2AB);
        drive(1'b0, 10'h000);
        drive(1'b1, 10'h100);
        drive(1'b1, 10'h2FF);
        drive(1'b1, 10'h0AB);
        drive(1'b0, 10'h000);

        // Random traffic with periodic blanking runs.
        for (int i = 0; i < 1500; i++) begin
            logic [9:0] w;
            bit         v;
            if (i % 200 == 0)
                for (int k = 0; k < 9; k++) drive(1'b1, tok_tab[$urandom_range(0, 3)]);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) w = tok_tab[$urandom_range(0, 3)];
            else w = 10'($urandom);
            drive(v, w);
        end
        do_reset();

        // Locked, then lose blanking until unlock; relock needs a clean run.
        for (int i = 0; i < TOKEN_RUN; i++) drive(1'b1, 10'h154);
        n = 0;
        for (int i = 0; i < SEARCH_TIMEOUT + 100 && locked; i++) begin
            drive(1'b1, 10'h1F0);
            n++;
        end
        chk("unlock_words", 16'(n), 16'(SEARCH_TIMEOUT));
        chk("unlock_no_slip", 16'(bitslip), 16'h0);
        for (int i = 0; i < 7; i++) drive(1'b1, 10'h0AB);
        drive(1'b1, 10'h1F0);
        for (int i = 0; i < 7; i++) drive(1'b1, 10'h0AB);
        chk("no_lock_split_run", 16'(locked), 16'h0);
        drive(1'b1, 10'h0AB);
        chk("relock", 16'(locked), 16'h1);
        drive(1'b1, 10'h1F0);
        drive(1'b1, 10'h354);

        // Misaligned token stream: bitslip until it decodes as tokens.
        do_reset();
        ser_off   = 8;
        dut_slips = 0;
        for (int i = 0; i < 12000 && !locked; i++) drive(1'b1, rot_word(10'h354, ser_off));
        chk("slips_to_lock", 16'(dut_slips), 16'd2);
        chk("rotated_locked", 16'(locked), 16'h1);
        for (int i = 0; i < 4; i++) drive(1'b1, rot_word(10'h354, ser_off));
`ifdef TMDS_RX_STATS_EN
        chk("slip_count_o", slip_count, 16'(m_slips));
        chk("unlock_count_o", 16'(unlock_count), 16'(m_unlocks));
`endif

        for (int i = 0; i < 4; i++) drive(1'b0, '0);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
